// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bundle of client-side and multiplier-side signals around
// the shared-multiplier arbiter.
//   req/operand_a/operand_b : client requests and packed operand pairs
//   grant/done/result/err   : per-client grant, completion pulse, product, timeout flag
//   busy                    : arbiter is not idle
//   mul_start/mul_multiplicand/mul_multiplier : launch side of the multiplier
//   mul_product/mul_ready   : multiplier result and Ready handshake
// Modports:
//   master : the environment (clients plus the multiplier instance)
//   slave  : the arbiter itself
interface mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] operand_a;
  logic [NUM_REQ*WIDTH-1:0] operand_b;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [2*WIDTH-1:0]       result;
  logic                     err;
  logic                     busy;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_multiplicand;
  logic [WIDTH-1:0]         mul_multiplier;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     mul_ready;

  modport master (
    output req, operand_a, operand_b, mul_product, mul_ready,
    input  grant, done, result, err, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );

  modport slave (
    input  req, operand_a, operand_b, mul_product, mul_ready,
    output grant, done, result, err, busy,
           mul_start, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer sharing one shift-add multiplier
// between NUM_REQ clients. A winner is launched with a one-cycle mul_start,
// its operands are held on the multiplier inputs, and the product is returned
// with a one-cycle done pulse. A stuck handshake is aborted after TIMEOUT
// wait cycles with err=1 and result=0.
// Ports:
//   clock   : rising-edge clock
//   reset_b : asynchronous active-low reset
//   bus     : mul_arbiter_if slave view (client and multiplier signals)
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset_b,
  mul_arbiter_if.slave bus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   last;       // most recently served client (also the active one)
  logic [TW-1:0]     tcnt;
  logic [WIDTH-1:0]  op_a [NUM_REQ];
  logic [WIDTH-1:0]  op_b [NUM_REQ];
  logic              win_valid;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW-1:0]   cand;
  logic              finish_ok;
  logic              finish_tmo;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign op_a[gi] = bus.operand_a[gi*WIDTH +: WIDTH];
      assign op_b[gi] = bus.operand_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: scan from last+1 upward (wrapping). Iterating from the
  // farthest candidate down lets the nearest requester overwrite the choice.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(last) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A normal completion wins over a timeout in the same cycle. The timeout is
  // only taken when the handshake is not progressing, so a WAIT_LOW->WAIT_HIGH
  // step at the limit is still honoured; the >= compare then catches it next.
  always_comb begin
    finish_ok  = (state == WAIT_HIGH) && bus.mul_ready;
    finish_tmo = 1'b0;
    if (((state == WAIT_LOW) && bus.mul_ready) ||
        ((state == WAIT_HIGH) && !bus.mul_ready)) begin
      finish_tmo = (tcnt >= TW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state                <= IDLE;
      last                 <= IDXW'(NUM_REQ - 1);
      tcnt                 <= '0;
      bus.grant            <= '0;
      bus.done             <= '0;
      bus.result           <= '0;
      bus.err              <= 1'b0;
      bus.busy             <= 1'b0;
      bus.mul_start        <= 1'b0;
      bus.mul_multiplicand <= '0;
      bus.mul_multiplier   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid && bus.mul_ready) begin
            bus.grant            <= NUM_REQ'(1) << win_idx;
            bus.mul_start        <= 1'b1;
            bus.mul_multiplicand <= op_a[win_idx];
            bus.mul_multiplier   <= op_b[win_idx];
            bus.busy             <= 1'b1;
            last                 <= win_idx;
            tcnt                 <= '0;
            state                <= START;
          end
        end
        START: begin
          bus.mul_start <= 1'b0;
          state         <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          tcnt <= tcnt + 1'b1;
          if (finish_ok || finish_tmo) begin
            bus.done[last] <= 1'b1;
            bus.grant      <= '0;
            bus.result     <= finish_ok ? bus.mul_product : '0;
            bus.err        <= finish_tmo;
            state          <= DONE;
          end else if ((state == WAIT_LOW) && !bus.mul_ready) begin
            state <= WAIT_HIGH;
          end
        end
        DONE: begin
          bus.done <= '0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized self-checking bench for mul_arbiter. A behavioural
// multiplier drives the Ready handshake; a scoreboard tracks pending requests,
// predicts each round-robin winner, product, latency and timeout outcome.
module tb_mul_arbiter;
  localparam int N   = 4;
  localparam int W   = 5;
  localparam int TMO = 64;

  logic clock   = 1'b0;
  logic reset_b = 1'b0;
  always #5 clock = ~clock;

  mul_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- multiplier model ----------------
  bit stuck    = 1'b0;   // Ready never drops
  bit hold_low = 1'b0;   // Ready forced low (multiplier unavailable)
  int lat      = 6;      // cycles Ready stays low after a start
  int mcnt     = 0;

  initial begin
    bus.mul_ready   = 1'b1;
    bus.mul_product = '0;
    forever begin
      @(negedge clock);
      if (!reset_b) begin
        bus.mul_ready = 1'b1;
        mcnt = 0;
      end else if (hold_low) begin
        bus.mul_ready = 1'b0;
      end else if (stuck) begin
        bus.mul_ready = 1'b1;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.mul_ready   = 1'b1;
          bus.mul_product = (2*W)'(bus.mul_multiplicand) * (2*W)'(bus.mul_multiplier);
        end
      end else if (bus.mul_start) begin
        bus.mul_ready   = 1'b0;
        bus.mul_product = (2*W)'($urandom);  // garbage while busy
        mcnt = lat;
      end else begin
        bus.mul_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] la [N];
  logic [W-1:0] lb [N];
  int  wait_cnt [N];
  int  served [$];
  int  cyc = 0;
  bit  in_txn = 1'b0;
  int  cur = 0;
  int  last_m = N - 1;
  int  launch_cyc = 0;
  int  done_cyc = -100;
  int  lat_used = 0;
  bit  exp_err = 1'b0;
  logic [W-1:0] exp_a, exp_b;

  function automatic int rr_pick(logic [N-1:0] p, int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic pack_ops();
    bus.operand_a = '0;
    bus.operand_b = '0;
    for (int i = 0; i < N; i++) begin
      bus.operand_a |= (N*W)'(la[i]) << (i*W);
      bus.operand_b |= (N*W)'(lb[i]) << (i*W);
    end
  endtask

  task automatic request(int i, logic [W-1:0] a, logic [W-1:0] b);
    la[i] = a;
    lb[i] = b;
    pack_ops();
    bus.req[i] = 1'b1;
    wait_cnt[i] = 0;
  endtask

  task automatic step();
    int w;
    @(negedge clock);
    cyc++;
    if (bus.done != '0) begin
      if (!in_txn) begin
        check_val("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        check_val("done", 64'(bus.done), 64'(1) << cur);
        check_val("result", 64'(bus.result),
                  exp_err ? 64'd0 : 64'(exp_a) * 64'(exp_b));
        check_val("err", 64'(bus.err), 64'(exp_err));
        check_val("grant_clear", 64'(bus.grant), 64'd0);
        check_val("op_hold", 64'({bus.mul_multiplicand, bus.mul_multiplier}),
                  64'({exp_a, exp_b}));
        if (exp_err)
          check_val("tmo_latency_ok",
                    64'((cyc - launch_cyc >= TMO) && (cyc - launch_cyc <= TMO + 2)), 64'd1);
        else
          check_val("latency", 64'(cyc - launch_cyc), 64'(lat_used + 1));
        $display("txn client=%0d a=%0d b=%0d result=%0d err=%0d", cur, exp_a, exp_b,
                 bus.result, bus.err);
        bus.req[cur] = 1'b0;
        in_txn   = 1'b0;
        done_cyc = cyc;
        served.push_back(cur);
      end
    end else if (in_txn) begin
      check_val("grant_hold", 64'(bus.grant), 64'(1) << cur);
      if (cyc == launch_cyc + 1) check_val("start_pulse", 64'(bus.mul_start), 64'd0);
    end else if (bus.grant != '0) begin
      w = rr_pick(bus.req, last_m);
      check_val("grant", 64'(bus.grant), (w < 0) ? 64'd0 : (64'(1) << w));
      check_val("start", 64'(bus.mul_start), 64'd1);
      check_val("busy", 64'(bus.busy), 64'd1);
      if (w >= 0) begin
        check_val("op_launch", 64'({bus.mul_multiplicand, bus.mul_multiplier}),
                  64'({la[w], lb[w]}));
        check_val("idle_gap", 64'(cyc - done_cyc >= 2), 64'd1);
        check_val("fairness", 64'(wait_cnt[w] <= N - 1), 64'd1);
        for (int i = 0; i < N; i++)
          if (i != w && bus.req[i]) wait_cnt[i]++;
        cur = w; last_m = w; in_txn = 1'b1; launch_cyc = cyc;
        exp_a = la[w]; exp_b = lb[w]; exp_err = stuck; lat_used = lat;
        // the client changes its operands after launch; must have no effect
        la[w] = W'($urandom);
        lb[w] = W'($urandom);
        pack_ops();
      end
    end else begin
      check_val("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((in_txn || bus.req != '0) && n < budget) begin
      step();
      n++;
    end
    check_val("drained", 64'({in_txn, bus.req}), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    check_val("rst_grant", 64'(bus.grant), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_result", 64'(bus.result), 64'd0);
    check_val("rst_err", 64'(bus.err), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_start", 64'(bus.mul_start), 64'd0);
    check_val("rst_ops", 64'({bus.mul_multiplicand, bus.mul_multiplier}), 64'd0);
    @(negedge clock);
    #2 reset_b = 1'b1;
    in_txn   = 1'b0;
    last_m   = N - 1;
    done_cyc = -100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req       = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    for (int i = 0; i < N; i++) begin
      la[i] = '0; lb[i] = '0; wait_cnt[i] = 0;
    end
    apply_reset();

    // single request, Ready low for 6 cycles
    lat = 6;
    request(0, 5'd3, 5'd3);
    drain(200);
    check_val("single_result", 64'(bus.result), 64'd9);

    // multiplier not ready: no grant may be issued
    hold_low = 1'b1;
    step();
    request(1, 5'd5, 5'd6);
    repeat (5) begin
      step();
      check_val("no_grant_not_ready", 64'(bus.grant), 64'd0);
    end
    hold_low = 1'b0;
    lat = 3;
    drain(200);
    check_val("late_result", 64'(bus.result), 64'd30);

    // contention after reset: order 0,1,2,3 then 0,2
    apply_reset();
    served.delete();
    lat = 4;
    request(0, 5'd1, 5'd2);
    request(1, 5'd2, 5'd3);
    request(2, 5'd3, 5'd4);
    request(3, 5'd4, 5'd5);
    drain(400);
    request(2, 5'd7, 5'd3);
    request(0, 5'd6, 5'd2);
    drain(400);
    check_val("order_len", 64'(served.size()), 64'd6);
    if (served.size() == 6) begin
      check_val("order0", 64'(served[0]), 64'd0);
      check_val("order1", 64'(served[1]), 64'd1);
      check_val("order2", 64'(served[2]), 64'd2);
      check_val("order3", 64'(served[3]), 64'd3);
      check_val("order4", 64'(served[4]), 64'd0);
      check_val("order5", 64'(served[5]), 64'd2);
    end

    // maximum operands
    request(3, 5'd31, 5'd31);
    drain(200);
    check_val("max_result", 64'(bus.result), 64'd961);

    // timeout, then a normal transaction
    stuck = 1'b1;
    request(0, 5'd7, 5'd9);
    drain(300);
    check_val("tmo_result", 64'(bus.result), 64'd0);
    stuck = 1'b0;
    request(1, 5'd6, 5'd7);
    drain(200);
    check_val("after_tmo_result", 64'(bus.result), 64'd42);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (!in_txn) lat = $urandom_range(2, 8);
      for (int i = 0; i < N; i++)
        if (!bus.req[i] && $urandom_range(0, 2) == 0)
          request(i, W'($urandom), W'($urandom));
      repeat ($urandom_range(1, 6)) step();
    end
    drain(3000);

    // reset in WAIT_HIGH of client 2 while client 1 pending
    apply_reset();
    served.delete();
    lat = 10;
    request(2, 5'd5, 5'd5);
    n = 0;
    while (!in_txn && n < 20) begin
      step();
      n++;
    end
    check_val("mid_granted", 64'(in_txn), 64'd1);
    request(1, 5'd3, 5'd4);
    repeat (4) step();
    apply_reset();
    lat = 3;
    drain(300);
    check_val("mid_len", 64'(served.size()), 64'd2);
    if (served.size() == 2) begin
      check_val("mid_first", 64'(served[0]), 64'd1);
      check_val("mid_second", 64'(served[1]), 64'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one shift-add binary multiplier between several requesters. It accepts operand pairs from `NUM_REQ` clients and launches the shared multiplier through its `start`/`Ready` handshake. When the product is valid, it returns the product to the winning client with a one-cycle done pulse. It sits between the client logic and the single multiplier instance, so clients never drive the multiplier directly.

## Interface

**Parameters**

- `NUM_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 5: operand width; the product is `2*WIDTH`.
- `TIMEOUT`, default 64: maximum cycles to wait on the multiplier handshake before aborting.

**Ports**

- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset_b`, in, 1: asynchronous, active-low reset.
- `req`, in, `NUM_REQ`: level request per client; held until that client's `done` bit is seen.
- `operand_a`, in, `NUM_REQ*WIDTH`: multiplicands; client i uses `[i*WIDTH +: WIDTH]`.
- `operand_b`, in, `NUM_REQ*WIDTH`: multipliers, sliced the same way as `operand_a`.
- `grant`, out, `NUM_REQ`: one-hot; high from launch until the done cycle.
- `done`, out, `NUM_REQ`: one-hot, one-cycle completion pulse.
- `result`, out, `2*WIDTH`: product; valid when `done` is high and held until the next `done`.
- `err`, out, 1: one-cycle pulse with `done` when the transaction timed out.
- `busy`, out, 1: high in every state except IDLE.
- `mul_start`, out, 1: start pulse to the multiplier.
- `mul_multiplicand`, out, `WIDTH`: operand to the multiplier; held stable from launch until done.
- `mul_multiplier`, out, `WIDTH`: operand to the multiplier; held stable from launch until done.
- `mul_product`, in, `2*WIDTH`: product from the multiplier.
- `mul_ready`, in, 1: multiplier Ready; high means idle with the product valid.

## Operation

**States:** IDLE, START, WAIT_LOW, WAIT_HIGH, DONE.

- **IDLE:** when any `req` bit is high and `mul_ready` is 1, pick the winner by round-robin.
  - Search starts at `last+1` mod `NUM_REQ`, where `last` is the most recently served client.
  - Next edge: set `grant[w]=1` and `mul_start=1`, latch that client's operands into `mul_multiplicand`/`mul_multiplier`, set `last=w`, go to START.
  - If `mul_ready` is 0, no grant is issued.
- **START:** `mul_start` is high for this cycle only. Next edge: `mul_start=0`, go to WAIT_LOW.
- **WAIT_LOW:** wait until `mul_ready` is sampled 0, then go to WAIT_HIGH.
- **WAIT_HIGH:** wait until `mul_ready` is sampled 1. On that edge:
  - `result <= mul_product` and `done[w] <= 1`;
  - `grant <= 0`;
  - go to DONE.
- **DONE:** `done` is high for exactly one cycle and `req` is ignored in this cycle. Next edge: `done=0`, go to IDLE.
- **Timeout counter:**
  - Cleared on launch; increments in WAIT_LOW and WAIT_HIGH.
  - On reaching `TIMEOUT`: go to DONE with `result=0`, `err=1`, `done[w]=1`, `grant=0`.
- **Requester rules:**
  - A client must deassert `req` by the edge that ends its done cycle.
  - A client that drops `req` mid-transaction still receives `done`. The transaction is never cancelled.
- **Operand changes:** changes to `operand_a`/`operand_b` after launch have no effect.
- **Arithmetic:** `result` is an unsigned `2*WIDTH` copy of `mul_product`; the arbiter does no arithmetic.

## Timing

- **Reset (asynchronous, takes effect immediately):**
  - `grant`, `done`, `result`, `err`, `busy`, `mul_start`, `mul_multiplicand`, `mul_multiplier` all go to 0.
  - State goes to IDLE, the timeout counter to 0, and `last` to `NUM_REQ-1`, so client 0 has first priority.
- **Reset mid-transaction:** the transaction is dropped with no `done` pulse. Pending requests are re-arbitrated after release.
- **Latency:**
  - Request sampled in IDLE → `grant`/`mul_start` at edge +1.
  - `mul_ready` sampled 1 in WAIT_HIGH → `done` at the next edge.
  - Minimum turnaround is 3 cycles plus the multiplier's busy time.
  - Back-to-back grants are separated by at least one IDLE cycle after DONE.
- **Simultaneous requests:** exactly one grant is issued; the others wait with `req` held.
- **Fairness:** each requesting client is served at most `NUM_REQ-1` transactions after it raises `req`.

## Test plan

- **Reset:** assert `reset_b=0` mid-clock → all outputs read 0 immediately and `busy=0`.
- **Single request:** client 0 requests with `a=3`, `b=3`, against a multiplier model whose Ready is low for 6 cycles.
  - Required: `grant=0001` and a single `mul_start` pulse with operands 3/3.
  - Then `done=0001`, `result=0000001001`, `err=0`.
- **Contention:** all four clients request in the same cycle with operands (1,2), (2,3), (3,4), (4,5).
  - Required: service order 0,1,2,3, with results 2, 6, 12, 20.
  - Then clients 2 and 0 re-request together → order 0, then 2.
- **Maximum operands:** `a=31`, `b=31` → `result=1111000001` (961).
- **Timeout:** the model holds Ready high and never drops it.
  - Required: after 64 cycles, `done` on the granted client with `err=1`, `result=0`.
  - A following request on client 1 then completes normally.
- **Reset mid-transaction:** pulse `reset_b` low during WAIT_HIGH for client 2 while client 1 is pending.
  - Required: no `done` pulse for client 2.
  - After release: client 1 is granted first if it is the only request; with both pending, client 1 wins because client 0 has top priority and client 1 is next in order.
